pp_buf_reader: RTL and testbench
================================

// Module: pp_buf_reader
// PURPOSE
//  Read side of the ping-pong buffer. Drains whichever of the two dp_ram banks the writer has
//  marked full through port B (enb/addrb/dob), and streams it out as an AXI4-Stream master.
//  Banks are read in strict alternation 0,1,0,... After the last word of a bank is accepted
//  downstream, a one-cycle bank_done pulse hands that bank back to the writer.
// PARAMETERS
//  DATA_WIDTH  32  word width; matches dp_ram DATA_WIDTH
//  DEPTH       16  words per bank; the whole bank is streamed
//  ADDRW       4   address width; must be >= clog2(DEPTH)
//  CNTW        16  width of the bank_cnt status counter
// PORTS
//  clk            in   1           single clock; all logic on posedge
//  rst            in   1           synchronous, active-high reset
//  bank_full      in   2           level, one bit per bank; 1 = bank holds DEPTH valid words
//  bank_done      out  2           one-hot, 1-cycle pulse; bank drained and free for the writer
//  rd_en          out  2           one-hot enb to dp_ram bank 0/1 port B
//  rd_addr        out  ADDRW       addrb, shared by both banks
//  rd_data0       in   DATA_WIDTH  dob of bank 0 (combinational read of rd_addr)
//  rd_data1       in   DATA_WIDTH  dob of bank 1
//  m_axis_tdata   out  DATA_WIDTH  stream data
//  m_axis_tvalid  out  1           stream valid
//  m_axis_tready  in   1           stream ready
//  m_axis_tlast   out  1           high on word DEPTH-1 of each bank
//  rd_bank        out  1           bank currently owned or awaited by the reader
//  busy           out  1           1 when state != IDLE
//  bank_cnt       out  CNTW        count of banks fully drained; wraps modulo 2^CNTW
// BEHAVIOUR
//  - Reset: state IDLE, rd_bank=0, rd_addr=0, rd_en=0, bank_done=0, tvalid=0, tlast=0, tdata=0,
//    bank_cnt=0. Reset mid-bank aborts it: tvalid drops the cycle after rst, no bank_done pulse.
//  - Port B read is combinational. Data selected at rd_addr = rd_data[rd_bank], same cycle.
//  - States: IDLE, READ, DRAIN.
//  - IDLE: bank_full[rd_bank] is sampled only here. If 1 -> READ with rd_addr=0.
//    bank_full of the other bank is ignored (strict alternation).
//  - READ: rd_en[rd_bank]=1. load = !tvalid | tready.
//    On load: tdata <= rd_data[rd_bank]; tvalid <= 1; tlast <= (rd_addr==DEPTH-1).
//    If rd_addr==DEPTH-1 -> DRAIN, else rd_addr++.
//    Sustains 1 word/clk while tready=1.
//  - DRAIN: rd_en=0. Wait for the handshake on the tlast word (tvalid & tready). On that edge:
//    tvalid<=0, tlast<=0, bank_done[rd_bank]<=1 for exactly one cycle, bank_cnt++,
//    rd_bank toggles, rd_addr<=0, -> IDLE.
//  - Latency: bank_full sampled 1 in IDLE at edge N -> READ at N+1 -> tvalid=1 after edge N+1.
//    Minimum gap between the tlast handshake and the next bank's first tvalid: 2 cycles.
//  - AXI rules: while tvalid & !tready, tdata/tlast are held and rd_addr does not advance.
//    tvalid never drops without a handshake, except on rst.
//  - The writer must hold bank_full=1 until it sees bank_done. Deassertion during READ/DRAIN
//    is ignored.
//  - Both banks full at once: only rd_bank is served. The other bank is served after toggling.
// TESTING  (DEPTH=16, DATA_WIDTH=32, bank k word i preloaded = {k[15:0], i[15:0]})
//  1 bank_full=01, tready=1 -> 16 beats 0x0000_0000..0x0000_000F back-to-back; tlast on beat 15;
//    bank_done=01 one cycle after the last handshake; bank_cnt=1; rd_bank=1.
//  2 bank_full=11 from reset, tready=1 -> 32 beats, bank0 then bank1 (0x0001_0000..0x0001_000F);
//    bank_done pulses 01 then 10; bank_cnt=2.
//  3 bank_full=01, tready random 50% -> beats arrive in order with no loss or duplicates;
//    tdata/tlast stable while stalled.
//  4 bank_full=10 only, after reset -> no tvalid and busy stays 0 (waits on bank 0).
//    Then assert bank 0 -> bank 0 streams first.
//  5 rst=1 at beat 7 of bank 0 -> tvalid=0 next cycle, no bank_done.
//    After rst release with bank_full=01: restarts at word 0, rd_bank=0.
//  6 tready=0 held 20 cycles on beat 15 -> tvalid=1, tlast=1 held; bank_done stays 0
//    until tready rises.

Source files
------------

// File: rtl/pp_buf_reader.sv
// pp_buf_reader: read side of a ping-pong buffer.
// Drains the bank the writer has marked full over dp_ram port B and streams
// it out as an AXI4-Stream master. Banks are served in strict alternation
// 0,1,0,... and each drained bank is handed back with a one-cycle bank_done.
module pp_buf_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDRW      = 4,
    parameter int CNTW       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            bank_full,
    output logic [1:0]            bank_done,
    output logic [1:0]            rd_en,
    output logic [ADDRW-1:0]      rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  rd_bank,
    output logic                  busy,
    output logic [CNTW-1:0]       bank_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for bank_full[rd_bank]
        ST_READ  = 2'd1,   // fetching words 0..DEPTH-1 into the output register
        ST_DRAIN = 2'd2    // last word loaded, waiting for its handshake
    } state_e;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

    state_e                  state_q,  state_d;
    logic                    rd_bank_q, rd_bank_d;
    logic [ADDRW-1:0]        rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   tdata_q,  tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q,  tlast_d;
    logic [1:0]              bank_done_q, bank_done_d;
    logic [CNTW-1:0]         bank_cnt_q, bank_cnt_d;

    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    load;
    logic                    last_hs;

    // Port B read is combinational: pick the word of the bank being served.
    always_comb begin
        sel_data = rd_bank_q ? rd_data1 : rd_data0;
        // The output register may take a new word when empty or being emptied.
        load     = !tvalid_q || m_axis_tready;
        last_hs  = tvalid_q && m_axis_tready;
    end

    // Next-state and next-register logic for the reader FSM.
    always_comb begin
        // NOTE: every _d signal gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_addr_d   = rd_addr_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        bank_done_d = 2'b00;        // pulse: high only on the cycle it is set
        bank_cnt_d  = bank_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Only the awaited bank counts; the other bank's flag is ignored.
                if (bank_full[rd_bank_q]) begin
                    state_d   = ST_READ;
                    rd_addr_d = '0;
                end
            end

            ST_READ: begin
                if (load) begin
                    tdata_d  = sel_data;
                    tvalid_d = 1'b1;
                    tlast_d  = (rd_addr_q == LAST_ADDR);
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                // Bank ownership returns to the writer only once the tlast
                // word has actually left.
                if (last_hs) begin
                    tvalid_d               = 1'b0;
                    tlast_d                = 1'b0;
                    bank_done_d[rd_bank_q] = 1'b1;
                    bank_cnt_d             = bank_cnt_q + 1'b1;
                    rd_bank_d              = !rd_bank_q;
                    rd_addr_d              = '0;
                    state_d                = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments only, so every
        // flop samples the values from before this edge.
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            bank_done_q <= 2'b00;
            bank_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            bank_done_q <= bank_done_d;
            bank_cnt_q  <= bank_cnt_d;
        end
    end

    // Output mapping; the port-B enable follows the READ state directly.
    always_comb begin
        rd_en         = 2'b00;
        if (state_q == ST_READ) begin
            rd_en[rd_bank_q] = 1'b1;
        end
        rd_addr       = rd_addr_q;
        m_axis_tdata  = tdata_q;
        m_axis_tvalid = tvalid_q;
        m_axis_tlast  = tlast_q;
        rd_bank       = rd_bank_q;
        busy          = (state_q != ST_IDLE);
        bank_done     = bank_done_q;
        bank_cnt      = bank_cnt_q;
    end

endmodule

// File: tb/tb_pp_buf_reader.sv
// Bench for pp_buf_reader: two behavioural dp_ram banks, a scoreboard of
// expected beats filled by the stimulus, and an independent negedge monitor.
module tb_pp_buf_reader;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    bank_full;
    logic [1:0]    bank_done;
    logic [1:0]    rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data0, rd_data1;
    logic [DW-1:0] tdata;
    logic          tvalid, tready, tlast;
    logic          rd_bank, busy;
    logic [CW-1:0] bank_cnt;

    pp_buf_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRW(AW), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .bank_full(bank_full), .bank_done(bank_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .rd_bank(rd_bank), .busy(busy), .bank_cnt(bank_cnt)
    );

    always #5 clk = ~clk;

    // Bank contents; a bank read without its enable returns a poison word.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    assign rd_data0 = rd_en[0] ? mem0[rd_addr] : 32'hDEAD_BEEF;
    assign rd_data1 = rd_en[1] ? mem1[rd_addr] : 32'hDEAD_BEEF;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          bank;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    popped = 0;
    int    mode   = 0;     // tready policy: 0 always, 1 random, 2 held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload_pattern();
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = {16'h0000, 16'(i)};
            mem1[i] = {16'h0001, 16'(i)};
        end
    endtask

    task automatic preload_random();
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = $urandom;
            mem1[i] = $urandom;
        end
    endtask

    // Expected stream of one bank: every word in address order, tlast on the end.
    task automatic push_bank(input int k);
        beat_t b;
        for (int i = 0; i < DEPTH; i++) begin
            b.data = (k == 1) ? mem1[i] : mem0[i];
            b.last = (i == DEPTH - 1);
            b.bank = (k == 1);
            sb.push_back(b);
        end
    endtask

    // Writer model: hold bank_full[k] until bank_done[k], then release it.
    task automatic wait_done(input int k, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #1;
            if (bank_done[k]) begin
                bank_full[k] = 1'b0;
                found = 1'b1;
            end
        end
        check($sformatf("bank_done_seen_%0d", k), found, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_tvalid",    tvalid,    0);
        check("rst_tlast",     tlast,     0);
        check("rst_tdata",     tdata,     0);
        check("rst_bank_done", bank_done, 0);
        check("rst_rd_en",     rd_en,     0);
        check("rst_rd_addr",   rd_addr,   0);
        check("rst_rd_bank",   rd_bank,   0);
        check("rst_busy",      busy,      0);
        check("rst_bank_cnt",  bank_cnt,  0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // tready driver, updated just after each edge.
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (mode)
                0:       tready = 1'b1;
                1:       tready = 1'($urandom_range(0, 1));
                default: tready = 1'b0;
            endcase
        end
    end

    // Monitor: sampled mid-cycle, a handshake seen here completes on the next edge.
    logic [1:0]    exp_done = 2'b00;
    logic [CW-1:0] model_cnt = '0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_done  = 2'b00;
            model_cnt = '0;
            hold_pend = 1'b0;
        end else begin
            check("bank_done", bank_done, exp_done);
            if (exp_done != 2'b00) begin
                check("bank_cnt_at_done", bank_cnt, model_cnt);
                check("rd_bank_at_done", rd_bank, exp_done[0]);
            end
            exp_done = 2'b00;
            if (hold_pend) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata",  tdata,  prev_data);
                check("stall_tlast",  tlast,  prev_last);
            end
            hold_pend = tvalid && !tready;
            prev_data = tdata;
            prev_last = tlast;
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tdata 0x%0h with nothing expected at %0t", tdata, $time);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat_tdata", tdata, e.data);
                    check("beat_tlast", tlast, e.last);
                    popped++;
                    if (e.last) begin
                        model_cnt = model_cnt + 1'b1;
                        exp_done  = e.bank ? 2'b10 : 2'b01;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst       = 1'b1;
        bank_full = 2'b00;
        preload_pattern();
        @(posedge clk); #1;

        // Single bank, full throughput.
        mode = 0;
        do_reset();
        bank_full = 2'b01;
        push_bank(0);
        wait_done(0, 200);
        check("t1_bank_cnt", bank_cnt, 1);
        check("t1_rd_bank",  rd_bank,  1);
        check("t1_sb_empty", sb.size(), 0);

        // Both banks full from reset: bank 0 then bank 1.
        do_reset();
        bank_full = 2'b11;
        push_bank(0);
        push_bank(1);
        wait_done(0, 200);
        wait_done(1, 200);
        check("t2_bank_cnt", bank_cnt, 2);
        check("t2_sb_empty", sb.size(), 0);

        // Random backpressure over several alternating banks with random data.
        do_reset();
        mode = 1;
        preload_random();
        for (int j = 0; j < 4; j++) begin
            bank_full[j % 2] = 1'b1;
            push_bank(j % 2);
            wait_done(j % 2, 400);
        end
        check("t3_bank_cnt", bank_cnt, 4);
        check("t3_sb_empty", sb.size(), 0);
        mode = 0;
        preload_pattern();

        // Only bank 1 full: the reader keeps waiting on bank 0.
        do_reset();
        bank_full = 2'b10;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            check("t4_idle_tvalid", tvalid, 0);
            check("t4_idle_busy",   busy,   0);
        end
        bank_full = 2'b11;
        push_bank(0);
        push_bank(1);
        wait_done(0, 200);
        wait_done(1, 200);
        check("t4_sb_empty", sb.size(), 0);

        // Reset while beat 7 of bank 0 is on the bus.
        do_reset();
        bank_full = 2'b01;
        push_bank(0);
        base = popped;
        for (int i = 0; i < 200 && (popped - base) < 7; i++) @(posedge clk);
        check("t5_reached_beat7", popped - base, 7);
        #1;
        do_reset();
        push_bank(0);
        wait_done(0, 200);
        check("t5_bank_cnt", bank_cnt, 1);
        check("t5_sb_empty", sb.size(), 0);

        // Long stall on the tlast beat.
        do_reset();
        bank_full = 2'b01;
        push_bank(0);
        base = popped;
        for (int i = 0; i < 200 && (popped - base) < 15; i++) @(posedge clk);
        check("t6_reached_beat15", popped - base, 15);
        mode = 2;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("t6_stall_tvalid",    tvalid,    1);
            check("t6_stall_tlast",     tlast,     1);
            check("t6_stall_bank_done", bank_done, 0);
        end
        mode = 0;
        wait_done(0, 50);
        check("t6_bank_cnt", bank_cnt, 1);
        check("t6_sb_empty", sb.size(), 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
